// File: rtl/dmem_sram_bridge_if.sv
// Bundle of the load/store request/response handshake and the data SRAM port
// for dmem_sram_bridge. The bridge takes the slave view; whoever drives the
// CPU side and models the SRAM takes the master view.
interface dmem_sram_bridge_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport master (
    output req_valid, req_wr, req_size, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  sram_en, sram_wen, sram_addr, sram_wdata,
    output sram_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_size, req_signed, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output sram_en, sram_wen, sram_addr, sram_wdata,
    input  sram_rdata
  );

endinterface

// File: rtl/dmem_sram_bridge.sv
// Data-side bridge from the CPU load/store stage to the data SRAM port.
// One request at a time: stores and misaligned accesses answer one cycle
// after issue, loads answer RD_LAT+1 cycles after issue with aligned and
// extended data. RD_LAT must lie in 1..4.
// Optional feature macro: DMEM_ADDR_MAP_EN -- when defined, kseg0/kseg1
// addresses (0x8000_0000..0xBFFF_FFFF) are folded to physical by masking
// with 0x1FFF_FFFF; otherwise addresses pass through unchanged.
module dmem_sram_bridge #(
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  dmem_sram_bridge_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  state_e      state_q, state_d;
  logic [1:0]  latCnt_q;
  logic [1:0]  loadSize_q;
  logic        loadSigned_q;
  logic [1:0]  loadOfs_q;
  logic [31:0] respRdata_q;
  logic        respErr_q;

  logic        reqReady;
  logic        accept;
  logic        misaligned;
  logic        issue;
  logic [31:0] translated;
  logic [31:0] shifted;
  logic [31:0] loadData;

  // Request qualification: a request is taken only in IDLE outside reset,
  // and a bad size/alignment never reaches the SRAM.
  always_comb begin
    reqReady   = (state_q == IDLE) && !reset;
    accept     = bus.req_valid && reqReady;
    misaligned = (bus.req_size == 2'd3) ||
                 ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                 ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00));
    issue      = accept && !misaligned;
  end

  // Virtual-to-physical address translation for the SRAM port.
  always_comb begin
`ifdef DMEM_ADDR_MAP_EN
    if (bus.req_addr[31:30] == 2'b10) begin
      translated = bus.req_addr & 32'h1FFF_FFFF;
    end else begin
      translated = bus.req_addr;
    end
`else
    translated = bus.req_addr;
`endif
  end

  // Load alignment: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted  = bus.sram_rdata >> {loadOfs_q, 3'b000};
    loadData = shifted;
    case (loadSize_q)
      2'd0: loadData = loadSigned_q ? {{24{shifted[7]}}, shifted[7:0]}
                                    : {24'b0, shifted[7:0]};
      2'd1: loadData = loadSigned_q ? {{16{shifted[15]}}, shifted[15:0]}
                                    : {16'b0, shifted[15:0]};
      default: loadData = shifted;
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: loads wait out the SRAM latency, everything else
  // goes straight to the one-cycle response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (misaligned || bus.req_wr) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (latCnt_q == 2'd0) begin
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: SRAM strobes only in the issue cycle, response flag in RESP.
  always_comb begin
    bus.req_ready  = reqReady;
    bus.resp_valid = (state_q == RESP);
    bus.resp_rdata = respRdata_q;
    bus.resp_err   = respErr_q;
    bus.sram_en    = issue;
    bus.sram_wen   = 4'b0000;
    bus.sram_addr  = 32'b0;
    bus.sram_wdata = 32'b0;
    if (issue) begin
      bus.sram_addr = {translated[31:2], 2'b00};
      if (bus.req_wr) begin
        case (bus.req_size)
          2'd0: begin
            bus.sram_wen   = 4'b0001 << bus.req_addr[1:0];
            bus.sram_wdata = {4{bus.req_wdata[7:0]}};
          end
          2'd1: begin
            bus.sram_wen   = 4'b0011 << bus.req_addr[1:0];
            bus.sram_wdata = {2{bus.req_wdata[15:0]}};
          end
          default: begin
            bus.sram_wen   = 4'b1111;
            bus.sram_wdata = bus.req_wdata;
          end
        endcase
      end
    end
  end

  // Transaction context and response registers; response data holds until
  // the next response is produced.
  always_ff @(posedge clk) begin
    if (reset) begin
      latCnt_q     <= 2'd0;
      loadSize_q   <= 2'd0;
      loadSigned_q <= 1'b0;
      loadOfs_q    <= 2'd0;
      respRdata_q  <= 32'b0;
      respErr_q    <= 1'b0;
    end else begin
      if (accept) begin
        loadSize_q   <= bus.req_size;
        loadSigned_q <= bus.req_signed;
        loadOfs_q    <= bus.req_addr[1:0];
        latCnt_q     <= LAT_INIT;
        if (misaligned) begin
          respRdata_q <= 32'b0;
          respErr_q   <= 1'b1;
        end else if (bus.req_wr) begin
          respRdata_q <= 32'b0;
          respErr_q   <= 1'b0;
        end
      end
      if (state_q == WAIT) begin
        if (latCnt_q == 2'd0) begin
          respRdata_q <= loadData;
          respErr_q   <= 1'b0;
        end else begin
          latCnt_q <= latCnt_q - 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Directed testbench for dmem_sram_bridge (RD_LAT = 2). Inputs change and
// outputs are sampled just after the falling edge. Expected SRAM addresses
// follow DMEM_ADDR_MAP_EN when it is defined for the build.
module tb_dmem_sram_bridge;

  localparam int LAT = 2;

`ifdef DMEM_ADDR_MAP_EN
  localparam logic [31:0] EXP_A_1003 = 32'h0000_1000;
  localparam logic [31:0] EXP_A_A002 = 32'h0000_0000;
  localparam logic [31:0] EXP_A_8010 = 32'h0000_0010;
  localparam logic [31:0] EXP_A_9FC4 = 32'h1FC0_0004;
`else
  localparam logic [31:0] EXP_A_1003 = 32'h8000_1000;
  localparam logic [31:0] EXP_A_A002 = 32'hA000_0000;
  localparam logic [31:0] EXP_A_8010 = 32'h8000_0010;
  localparam logic [31:0] EXP_A_9FC4 = 32'h9FC0_0004;
`endif

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   enPulses = 0;
  int   startPulses;

  dmem_sram_bridge_if busIf ();

  dmem_sram_bridge #(.RD_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (busIf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (busIf.sram_en === 1'b1) enPulses <= enPulses + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    busIf.req_wr     = wr;
    busIf.req_size   = size;
    busIf.req_signed = sgn;
    busIf.req_addr   = addr;
    busIf.req_wdata  = wdata;
    busIf.req_valid  = 1'b1;
    #1;
  endtask

  task automatic storeCase(input string tag, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] expAddr,
                           input logic [3:0] expWen, input logic [31:0] expWdata);
    applyStimulus(1'b1, size, 1'b0, addr, wdata);
    checkOutput({tag, "_en"}, 32'(busIf.sram_en), 32'd1);
    checkOutput({tag, "_wen"}, 32'(busIf.sram_wen), 32'(expWen));
    checkOutput({tag, "_addr"}, busIf.sram_addr, expAddr);
    checkOutput({tag, "_wdata"}, busIf.sram_wdata, expWdata);
    @(negedge clk);
    busIf.req_valid = 1'b0;
    #1;
    checkOutput({tag, "_rv"}, 32'(busIf.resp_valid), 32'd1);
    checkOutput({tag, "_err"}, 32'(busIf.resp_err), 32'd0);
    checkOutput({tag, "_rdata"}, busIf.resp_rdata, 32'd0);
    checkOutput({tag, "_en_t1"}, 32'(busIf.sram_en), 32'd0);
    checkOutput({tag, "_rdy_t1"}, 32'(busIf.req_ready), 32'd0);
    @(negedge clk);
    #1;
    checkOutput({tag, "_rv_t2"}, 32'(busIf.resp_valid), 32'd0);
    checkOutput({tag, "_rdy_t2"}, 32'(busIf.req_ready), 32'd1);
  endtask

  task automatic loadCase(input string tag, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] expAddr,
                          input logic [31:0] rdataVal, input logic [31:0] expData);
    applyStimulus(1'b0, size, sgn, addr, 32'hFFFF_FFFF);
    busIf.sram_rdata = 32'hDEAD_BEEF;
    #1;
    checkOutput({tag, "_en"}, 32'(busIf.sram_en), 32'd1);
    checkOutput({tag, "_wen"}, 32'(busIf.sram_wen), 32'd0);
    checkOutput({tag, "_addr"}, busIf.sram_addr, expAddr);
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      busIf.req_valid  = 1'b0;
      busIf.sram_rdata = (c == LAT) ? rdataVal : 32'hDEAD_BEEF;
      #1;
      checkOutput({tag, "_rv_wait"}, 32'(busIf.resp_valid), 32'd0);
      checkOutput({tag, "_rdy_wait"}, 32'(busIf.req_ready), 32'd0);
      checkOutput({tag, "_en_wait"}, 32'(busIf.sram_en), 32'd0);
    end
    @(negedge clk);
    busIf.sram_rdata = 32'hDEAD_BEEF;
    #1;
    checkOutput({tag, "_rv"}, 32'(busIf.resp_valid), 32'd1);
    checkOutput({tag, "_rdata"}, busIf.resp_rdata, expData);
    checkOutput({tag, "_err"}, 32'(busIf.resp_err), 32'd0);
    @(negedge clk);
    #1;
    checkOutput({tag, "_rv_after"}, 32'(busIf.resp_valid), 32'd0);
    checkOutput({tag, "_hold"}, busIf.resp_rdata, expData);
    checkOutput({tag, "_rdy_after"}, 32'(busIf.req_ready), 32'd1);
  endtask

  task automatic errCase(input string tag, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr);
    applyStimulus(wr, size, 1'b0, addr, 32'h1234_5678);
    checkOutput({tag, "_en"}, 32'(busIf.sram_en), 32'd0);
    checkOutput({tag, "_wen"}, 32'(busIf.sram_wen), 32'd0);
    @(negedge clk);
    busIf.req_valid = 1'b0;
    #1;
    checkOutput({tag, "_rv"}, 32'(busIf.resp_valid), 32'd1);
    checkOutput({tag, "_err"}, 32'(busIf.resp_err), 32'd1);
    checkOutput({tag, "_rdata"}, busIf.resp_rdata, 32'd0);
    checkOutput({tag, "_en_t1"}, 32'(busIf.sram_en), 32'd0);
    @(negedge clk);
    #1;
    checkOutput({tag, "_rv_t2"}, 32'(busIf.resp_valid), 32'd0);
    checkOutput({tag, "_err_hold"}, 32'(busIf.resp_err), 32'd1);
  endtask

  initial begin
    reset            = 1'b1;
    busIf.req_valid  = 1'b0;
    busIf.req_wr     = 1'b0;
    busIf.req_size   = 2'd0;
    busIf.req_signed = 1'b0;
    busIf.req_addr   = 32'd0;
    busIf.req_wdata  = 32'd0;
    busIf.sram_rdata = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_ready", 32'(busIf.req_ready), 32'd0);
    checkOutput("rst_rv", 32'(busIf.resp_valid), 32'd0);
    checkOutput("rst_rdata", busIf.resp_rdata, 32'd0);
    checkOutput("rst_err", 32'(busIf.resp_err), 32'd0);
    checkOutput("rst_en", 32'(busIf.sram_en), 32'd0);
    checkOutput("rst_wen", 32'(busIf.sram_wen), 32'd0);
    checkOutput("rst_addr", busIf.sram_addr, 32'd0);
    checkOutput("rst_wdata", busIf.sram_wdata, 32'd0);
    busIf.req_valid = 1'b1;
    busIf.req_addr  = 32'h0000_0010;
    #1;
    checkOutput("rst_en_valid", 32'(busIf.sram_en), 32'd0);
    busIf.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_release_ready", 32'(busIf.req_ready), 32'd1);

    // Stores
    storeCase("sb", 2'd0, 32'h8000_1003, 32'h0000_00A5, EXP_A_1003, 4'b1000, 32'hA5A5_A5A5);
    storeCase("sh", 2'd1, 32'h0000_0202, 32'hFFFF_BEEF, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF);
    storeCase("sb1", 2'd0, 32'h0000_0301, 32'h0000_0042, 32'h0000_0300, 4'b0010, 32'h4242_4242);

    // Loads with alignment and extension
    loadCase("lh_s", 2'd1, 1'b1, 32'hA000_0002, EXP_A_A002, 32'h8001_1234, 32'hFFFF_8001);
    loadCase("lh_u", 2'd1, 1'b0, 32'hA000_0002, EXP_A_A002, 32'h8001_1234, 32'h0000_8001);
    loadCase("lb_s", 2'd0, 1'b1, 32'h0000_0001, 32'h0000_0000, 32'h1234_80FF, 32'hFFFF_FF80);
    loadCase("lb_u", 2'd0, 1'b0, 32'h0000_0003, 32'h0000_0000, 32'h9A34_80FF, 32'h0000_009A);
    loadCase("lh_s0", 2'd1, 1'b1, 32'h0000_0020, 32'h0000_0020, 32'h8001_7FFE, 32'h0000_7FFE);
    loadCase("lw", 2'd2, 1'b1, 32'h8000_0010, EXP_A_8010, 32'hCAFE_BABE, 32'hCAFE_BABE);

    // Error responses
    errCase("mis_lw", 1'b0, 2'd2, 32'h0000_0006);
    errCase("size3", 1'b0, 2'd3, 32'h0000_0000);
    errCase("mis_sh", 1'b1, 2'd1, 32'h0000_0001);

    // Back-to-back word stores with req_valid held high
    startPulses = enPulses;
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'h1111_2222);
    checkOutput("b2b_rdy0", 32'(busIf.req_ready), 32'd1);
    checkOutput("b2b_en0", 32'(busIf.sram_en), 32'd1);
    checkOutput("b2b_wen0", 32'(busIf.sram_wen), 32'hF);
    checkOutput("b2b_wdata0", busIf.sram_wdata, 32'h1111_2222);
    @(negedge clk);
    #1;
    checkOutput("b2b_rdy1", 32'(busIf.req_ready), 32'd0);
    checkOutput("b2b_en1", 32'(busIf.sram_en), 32'd0);
    checkOutput("b2b_rv1", 32'(busIf.resp_valid), 32'd1);
    checkOutput("b2b_err1", 32'(busIf.resp_err), 32'd0);
    @(negedge clk);
    busIf.req_addr  = 32'h0000_0104;
    busIf.req_wdata = 32'h3333_4444;
    #1;
    checkOutput("b2b_rdy2", 32'(busIf.req_ready), 32'd1);
    checkOutput("b2b_en2", 32'(busIf.sram_en), 32'd1);
    checkOutput("b2b_addr2", busIf.sram_addr, 32'h0000_0104);
    checkOutput("b2b_wdata2", busIf.sram_wdata, 32'h3333_4444);
    @(negedge clk);
    busIf.req_valid = 1'b0;
    #1;
    checkOutput("b2b_rv3", 32'(busIf.resp_valid), 32'd1);
    checkOutput("b2b_en3", 32'(busIf.sram_en), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("b2b_pulses", 32'(enPulses - startPulses), 32'd2);

    // Reset pulsed while a load waits for the SRAM
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'd0);
    busIf.sram_rdata = 32'h5555_5555;
    @(negedge clk);
    busIf.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("rw_rdy_rst", 32'(busIf.req_ready), 32'd0);
    checkOutput("rw_rv_rst", 32'(busIf.resp_valid), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("rw_rv_rst2", 32'(busIf.resp_valid), 32'd0);
    checkOutput("rw_rdata_clr", busIf.resp_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rw_rdy_back", 32'(busIf.req_ready), 32'd1);
    checkOutput("rw_rv_back", 32'(busIf.resp_valid), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("rw_rv_late", 32'(busIf.resp_valid), 32'd0);
    loadCase("lw_after_rst", 2'd2, 1'b0, 32'h0000_0020, 32'h0000_0020, 32'h1357_9BDF, 32'h1357_9BDF);

    // Addresses outside kseg0/kseg1 and inside kseg0
    storeCase("bfc0", 2'd2, 32'h1FC0_0000, 32'h0BAD_F00D, 32'h1FC0_0000, 4'b1111, 32'h0BAD_F00D);
    storeCase("9fc4", 2'd2, 32'h9FC0_0004, 32'h600D_CAFE, EXP_A_9FC4, 4'b1111, 32'h600D_CAFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_sram_bridge.md
# dmem_sram_bridge

Data-side bridge between the CPU's load/store stage and the data SRAM port of the top-level wrapper. Accepts one request at a time over a valid/ready handshake and performs kseg0/kseg1 address translation and byte-lane write-enable generation. Handles parametrised-latency reads with load alignment and sign/zero extension, and flags misaligned accesses without touching the SRAM. Replaces the fixed, word-only, zero-latency data-port glue in the current top level.

## Interface
- RD_LAT, 1: SRAM read latency in cycles, legal range 1–4.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept a request this cycle.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_signed  in  1  sign-extend load result; ignored for stores and word loads.
- req_addr  in  32  virtual byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal-size access.
- sram_en  out  1  SRAM access strobe.
- sram_wen  out  4  byte write enables.
- sram_addr  out  32  physical address, word-aligned.
- sram_wdata  out  32  lane-replicated store data.
- sram_rdata  in  32  SRAM read data, valid RD_LAT cycles after issue.

## Operation
- FSM states: IDLE, WAIT, RESP. req_ready = 1 only in IDLE and only while reset = 0.
- Accept a request when req_valid & req_ready (issue cycle T).
- Misalignment is defined as: half with addr[0] = 1, word with addr[1:0] ≠ 0, or size = 3.
- Misaligned request:
  - sram_en stays 0.
  - Go to RESP with resp_err = 1 and resp_rdata = 0.
- Store:
  - In cycle T, drive combinationally: sram_en = 1, sram_wen as below, sram_wdata = {4{b}} for byte, {2{h}} for half, raw data for word.
  - Go to RESP.
- Write enables: byte = 4'b0001 << addr[1:0]; half = 4'b0011 << addr[1:0]; word = 4'b1111.
- Load:
  - In cycle T, drive sram_en = 1 and sram_wen = 0.
  - Latch size, signed flag and addr[1:0].
  - Enter WAIT with a down-counter loaded to RD_LAT-1.
  - In the cycle where the counter is 0 and the state is WAIT, capture sram_rdata.
  - Capture rule: shift right by 8·addr[1:0], then extend the selected byte or half to 32 bits using req_signed.
  - Go to RESP.
- RESP lasts exactly one cycle: resp_valid = 1, then return to IDLE. The response has no backpressure.
- sram_en and sram_wen are 0 in every cycle except the issue cycle.
- sram_addr = {translated[31:2], 2'b00}.

## Timing
- Reset values: req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, sram_en = 0, sram_wen = 0, sram_addr = 0, sram_wdata = 0, state = IDLE.
- Reset asserted in WAIT or RESP aborts the transaction. No response is produced for it.
- Store and error latency: resp_valid in cycle T+1. The next request can be accepted in T+2.
- Load latency: sram_rdata is sampled in cycle T+RD_LAT, and resp_valid is asserted in T+RD_LAT+1.
- Load throughput: one request per RD_LAT+2 cycles.
- req_valid during WAIT or RESP is ignored; the requester must hold it.
- resp_rdata and resp_err are registered and hold their value after the RESP cycle until the next response.

## Configuration
- DMEM_ADDR_MAP_EN defined:
  - Virtual 0x8000_0000–0xBFFF_FFFF (kseg0/kseg1) is translated to physical addr & 0x1FFF_FFFF.
  - All other addresses pass through unchanged.
- DMEM_ADDR_MAP_EN undefined: translated = req_addr, identity mapping.

## Test plan
- Byte store: addr 0x8000_1003, wdata 0x0000_00A5, size 0 -> in T: sram_en = 1, sram_wen = 4'b1000, sram_addr = 0x0000_1000 (map enabled), sram_wdata = 0xA5A5_A5A5; resp_valid at T+1, resp_err = 0.
- Signed half load, RD_LAT = 2: addr 0xA000_0002, sram_rdata = 0x8001_1234 at T+2 -> resp_valid at T+3, resp_rdata = 0xFFFF_8001. Repeat unsigned -> 0x0000_8001.
- Misaligned word load at 0x0000_0006 -> sram_en never asserted, resp_valid at T+1, resp_err = 1, resp_rdata = 0. Also cover size = 3 -> same error response.
- Back-to-back word stores with req_valid held high -> accepts at T and T+2, req_ready = 0 at T+1, exactly two sram_en pulses.
- Reset pulsed during WAIT, RD_LAT = 4 -> no resp_valid is produced; req_ready returns to 1 the cycle after reset deasserts; a following load completes normally.
- Address 0x1FC0_0000 with DMEM_ADDR_MAP_EN defined -> sram_addr = 0x1FC0_0000 unchanged. Address 0x9FC0_0004 without the macro -> sram_addr = 0x9FC0_0004.
